pipe_elastic_stage: RTL and testbench
=====================================

// Module: pipe_elastic_stage
// PURPOSE
//  Parametrised elastic pipeline register for inter-stage boundaries (F/D, D/E, E/M, M/W).
//  Carries a CTRL_WIDTH control bundle and a DATA_WIDTH data bundle under a valid/ready handshake.
//  A 2-entry skid buffer registers in_ready, so there is no combinational out_ready->in_ready path.
//  flush_i inserts a bubble, and control is forced to zero whenever the stage holds no beat.
// PARAMETERS
//  CTRL_WIDTH  12  width of control bundle (RegWrite, ResultSrc, MemWrite, ...); zeroed on bubble
//  DATA_WIDTH  180 width of data bundle (RD1, RD2, PC, Rs1/Rs2/Rd, ImmExt, PCPlus4, ...)
// PORTS
//  clk        in   1           rising-edge clock
//  rst_n      in   1           asynchronous active-low reset
//  flush_i    in   1           synchronous flush (replaces CLR); highest priority after reset
//  in_valid   in   1           upstream beat valid
//  in_ready   out  1           stage can accept a beat this cycle
//  in_ctrl    in   CTRL_WIDTH  upstream control bundle
//  in_data    in   DATA_WIDTH  upstream data bundle
//  out_valid  out  1           downstream beat valid
//  out_ready  in   1           downstream accepts this cycle
//  out_ctrl   out  CTRL_WIDTH  control; all-zero whenever out_valid=0
//  out_data   out  DATA_WIDTH  data; stable while out_valid && !out_ready
//  occ        out  2           occupancy, 0..2 (1 max without PIPE_SKID_EN)
// BEHAVIOUR
//  - Handshake: accept = in_valid & in_ready; emit = out_valid & out_ready; one beat per cycle max each side.
//  - Latency: a beat accepted at edge N appears on out_* after edge N (1 cycle); sustained throughput 1/clk.
//  - Reset (async, rst_n=0): state EMPTY; main/skid slots zeroed; out_valid=0, out_ctrl=0, out_data=0,
//    occ=0, in_ready=1. Reset mid-transfer drops all held beats. Release is synchronous to clk.
//  - State machine (registered; pipe_state_e):
//    EMPTY: accept -> FULL, main<=in.
//    FULL:  accept&emit -> FULL, main<=in | accept&!emit -> SKID, skid<=in | !accept&emit -> EMPTY | else hold.
//    SKID:  emit -> FULL, main<=skid | else hold. in_ready=0 in this state.
//  - in_ready = (state != SKID), driven from the register only (no dependence on out_ready or in_valid).
//  - out_valid = (state != EMPTY); out_ctrl = out_valid ? main_ctrl : '0; out_data = main_data.
//  - occ = 0/1/2 for EMPTY/FULL/SKID.
//  - flush_i=1 at an edge: next state EMPTY; main and skid zeroed; any beat accepted that cycle is discarded.
//    A beat emitted during the flush cycle counts as consumed downstream; flush does not retract it.
//  - flush_i held high: stage stays EMPTY and in_ready stays 1, so upstream drains into the bubble.
//  - No wrap-around or overflow: SKID deasserts in_ready, so a third beat can never be accepted.
// CONFIGURATION
//  PIPE_SKID_EN defined: full 2-entry behaviour as above.
//  PIPE_SKID_EN undefined: single slot, with no SKID state and no skid storage.
//    - in_ready = out_ready | !out_valid (combinational path permitted).
//    - FULL & accept & !emit cannot occur. occ is 0..1.
//    - Flush and reset behaviour are unchanged.
// STRUCTURE
//  pipe_pkg (shared by all pipeline stages):
//    typedef enum logic [1:0] {EMPTY, FULL, SKID} pipe_state_e;
//    localparam OCC_W = 2.
//  Sub-module pipe_slot #(W): one register entry with load/clear inputs, async reset to 0.
//    Instantiated twice: main slot (CTRL+DATA) and skid slot (the latter only under PIPE_SKID_EN).
//  Top level contains the FSM, handshake logic and output gating.
// TESTING
//  1 Reset: assert rst_n=0 mid-stream with 2 beats held
//    -> out_valid=0, out_ctrl=0, out_data=0, occ=0 and in_ready=1 immediately, without waiting for a clk edge.
//  2 Streaming: in_valid=1 every cycle, out_ready=1, data 0x1..0x8
//    -> out_data 0x1..0x8 in order, each 1 cycle after acceptance, no gaps, occ=1 steady state.
//  3 Backpressure: FULL holding 0xA; out_ready=0 while 0xB is accepted
//    -> occ=2 and in_ready=0 next cycle; out_data holds 0xA.
//    Then out_ready=1 -> 0xA, then 0xB emitted; in_ready returns to 1 the cycle after the 0xA emit.
//  4 Flush: occ=2 (0xA, 0xB) and in_valid=1 with 0xC; pulse flush_i
//    -> next cycle occ=0, out_valid=0, out_ctrl=0; 0xA, 0xB and 0xC never appear at the output.
//  5 Bubble control: in_ctrl=all-ones with in_valid=0 for 3 cycles -> out_ctrl=0 throughout.
//  6 Build without PIPE_SKID_EN: out_ready=0 while FULL -> in_ready=0 in the same cycle.
//    Rerun scenarios 2 and 4 -> identical output sequence.

Source files
------------

// File: rtl/pipe_elastic_stage_pkg.sv
// Shared pipeline-stage types: occupancy state encoding and occupancy width.
// Used by every elastic stage boundary (F/D, D/E, E/M, M/W).
package pipe_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      FULL  = 2'd1,
      SKID  = 2'd2
   } pipe_state_e;

   localparam int OCC_W = 2;

   // State encoding doubles as the beat count held by the stage.
   function automatic logic [OCC_W-1:0] occ_of(input pipe_state_e s);
      return s;
   endfunction

endpackage

// File: rtl/pipe_elastic_stage_if.sv
// Valid/ready beat channel carrying a control bundle and a data bundle.
// master drives the beat, slave returns ready.
interface pipe_elastic_stage_if #(
   parameter int CTRL_WIDTH = 12,
   parameter int DATA_WIDTH = 180
);
   logic                  valid;
   logic                  ready;
   logic [CTRL_WIDTH-1:0] ctrl;
   logic [DATA_WIDTH-1:0] data;

   modport master (output valid, output ctrl, output data, input ready);
   modport slave  (input valid, input ctrl, input data, output ready);
endinterface

// File: rtl/pipe_elastic_stage_slot.sv
// One register entry of an elastic stage: load captures d, clear zeroes it.
// clear wins over load so a flush always leaves the entry empty.
module pipe_slot #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic         clear,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] data_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_reg <= '0;
      end else if (clear) begin
         data_reg <= '0;
      end else if (load) begin
         data_reg <= d;
      end
   end

   assign q = data_reg;

endmodule

// File: rtl/pipe_elastic_stage.sv
// Elastic pipeline register with flush and bubble-zeroed control.
// Define PIPE_SKID_EN for the 2-entry skid buffer with registered in_ready; otherwise single slot.
module pipe_elastic_stage
   import pipe_pkg::*;
#(
   parameter int CTRL_WIDTH = 12,
   parameter int DATA_WIDTH = 180
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                flush_i,
   pipe_elastic_stage_if.slave  in_if,
   pipe_elastic_stage_if.master out_if,
   output logic [OCC_W-1:0]    occ
);

   localparam int W = CTRL_WIDTH + DATA_WIDTH;

   pipe_state_e  state_reg;
   logic         accept;
   logic         emit;
   logic         out_valid;
   logic         main_load;
   logic [W-1:0] in_beat;
   logic [W-1:0] main_d;
   logic [W-1:0] main_q;

   assign in_beat   = {in_if.ctrl, in_if.data};
   assign out_valid = (state_reg != EMPTY);
   assign accept    = in_if.valid & in_if.ready;
   assign emit      = out_valid & out_if.ready;

`ifdef PIPE_SKID_EN
   logic         skid_load;
   logic [W-1:0] skid_q;

   // Ready comes straight from the state register, breaking the out_ready->in_ready path.
   assign in_if.ready = (state_reg != SKID);

   assign main_load = ((state_reg == EMPTY) && accept)
                    || ((state_reg == FULL) && accept && emit)
                    || ((state_reg == SKID) && emit);
   assign skid_load = (state_reg == FULL) && accept && !emit;
   assign main_d    = (state_reg == SKID) ? skid_q : in_beat;

   pipe_slot #(.W(W)) u_skid (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (skid_load),
      .clear (flush_i),
      .d     (in_beat),
      .q     (skid_q)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= EMPTY;
      end else if (flush_i) begin
         state_reg <= EMPTY;
      end else begin
         case (state_reg)
            EMPTY: if (accept) state_reg <= FULL;
            FULL: begin
               if (accept && !emit) begin
                  state_reg <= SKID;
               end else if (!accept && emit) begin
                  state_reg <= EMPTY;
               end
            end
            SKID:  if (emit) state_reg <= FULL;
            default: state_reg <= EMPTY;
         endcase
      end
   end
`else
   // Single slot: room exists when the held beat leaves this cycle or nothing is held.
   assign in_if.ready = out_if.ready | ~out_valid;
   assign main_load   = accept;
   assign main_d      = in_beat;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= EMPTY;
      end else if (flush_i) begin
         state_reg <= EMPTY;
      end else begin
         case (state_reg)
            EMPTY: if (accept) state_reg <= FULL;
            FULL:  if (emit && !accept) state_reg <= EMPTY;
            default: state_reg <= EMPTY;
         endcase
      end
   end
`endif

   pipe_slot #(.W(W)) u_main (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (main_load),
      .clear (flush_i),
      .d     (main_d),
      .q     (main_q)
   );

   // Stale main contents after a drain must not leak control into a bubble.
   assign out_if.valid = out_valid;
   assign out_if.ctrl  = out_valid ? main_q[W-1 -: CTRL_WIDTH] : '0;
   assign out_if.data  = main_q[DATA_WIDTH-1:0];
   assign occ          = occ_of(state_reg);

endmodule

// File: tb/tb_pipe_elastic_stage.sv
// Self-checking bench for pipe_elastic_stage; scoreboard tracks accepted beats against emitted ones.
// Skid-specific scenarios are selected by PIPE_SKID_EN, matching the RTL build.
module tb_pipe_elastic_stage;
   import pipe_pkg::*;

   localparam int CW = 12;
   localparam int DW = 180;
   localparam int BW = CW + DW;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             flush_i = 1'b0;
   logic [OCC_W-1:0] occ;

   int total = 0;
   int bad   = 0;
   logic [BW-1:0] sb[$];

   pipe_elastic_stage_if #(.CTRL_WIDTH(CW), .DATA_WIDTH(DW)) up ();
   pipe_elastic_stage_if #(.CTRL_WIDTH(CW), .DATA_WIDTH(DW)) dn ();

   pipe_elastic_stage #(.CTRL_WIDTH(CW), .DATA_WIDTH(DW)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush_i (flush_i),
      .in_if   (up),
      .out_if  (dn),
      .occ     (occ)
   );

   always #5 clk = ~clk;

   function automatic logic [BW-1:0] beat(input int v);
      logic [DW-1:0] d;
      logic [CW-1:0] c;
      logic [31:0]   u;
      u = v;
      d = '0;
      d[31:0] = u;
      d[DW-1 -: 16] = ~u[15:0];
      c = u[CW-1:0] ^ 12'hA5C;
      return {c, d};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int v);
      logic [BW-1:0] b;
      b = beat(v);
      up.valid = 1'b1;
      up.ctrl  = b[BW-1 -: CW];
      up.data  = b[DW-1:0];
   endtask

   task automatic idle();
      up.valid = 1'b0;
      up.ctrl  = '0;
      up.data  = '0;
   endtask

   // Scoreboard: emitted beats popped and compared, accepted beats pushed; flush/reset discard.
   always @(negedge clk) begin
      logic [BW-1:0] exp_b;
      if (!rst_n) begin
         sb.delete();
      end else begin
         if (dn.valid && dn.ready) begin
            total++;
            if (sb.size() == 0) begin
               bad++;
               $display("FAIL sb_unexpected: got %h want no beat", dn.data[31:0]);
            end else begin
               exp_b = sb.pop_front();
               $display("emit data=%h ctrl=%h", dn.data[31:0], dn.ctrl);
               if ({dn.ctrl, dn.data} !== exp_b) begin
                  bad++;
                  $display("FAIL sb_beat: got %h/%h want %h/%h", dn.ctrl, dn.data[31:0],
                           exp_b[BW-1 -: CW], exp_b[31:0]);
               end
            end
         end
         if (flush_i) sb.delete();
         else if (up.valid && up.ready) sb.push_back({up.ctrl, up.data});
         total++;
         if (!dn.valid && dn.ctrl !== '0) begin
            bad++;
            $display("FAIL bubble_ctrl: got %h want 0", dn.ctrl);
         end
      end
   end

   task automatic check_empty_outputs(input string tag);
      total++;
      if (dn.valid !== 1'b0 || dn.ctrl !== '0 || dn.data !== '0 || occ !== 2'd0 || up.ready !== 1'b1) begin
         bad++;
         $display("FAIL %s: got v=%b c=%h d=%h occ=%0d rdy=%b want 0/0/0/0/1",
                  tag, dn.valid, dn.ctrl, dn.data[31:0], occ, up.ready);
      end
   endtask

   task automatic test_reset();
      #2;
      check_empty_outputs("reset_initial");
      @(negedge clk);
      @(negedge clk);
      #1 rst_n = 1'b1;
      step();
      check_empty_outputs("reset_release");
   endtask

   task automatic test_stream();
      logic [BW-1:0] b;
      dn.ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         send(i);
         step();
         b = beat(i);
         total++;
         if (dn.valid !== 1'b1 || dn.data !== b[DW-1:0] || occ !== 2'd1) begin
            bad++;
            $display("FAIL stream_%0d: got v=%b d=%h occ=%0d want 1/%h/1",
                     i, dn.valid, dn.data[31:0], occ, b[31:0]);
         end
      end
      idle();
      step();
      total++;
      if (dn.valid !== 1'b0 || occ !== 2'd0) begin
         bad++;
         $display("FAIL stream_drain: got v=%b occ=%0d want 0/0", dn.valid, occ);
      end
   endtask

   task automatic test_backpressure();
      logic [BW-1:0] a;
      logic [BW-1:0] b;
      a = beat('hA);
      b = beat('hB);
      dn.ready = 1'b0;
      send('hA);
      step();
`ifdef PIPE_SKID_EN
      send('hB);
      step();
      idle();
      total++;
      if (occ !== 2'd2 || up.ready !== 1'b0 || dn.data !== a[DW-1:0]) begin
         bad++;
         $display("FAIL bp_skid: got occ=%0d rdy=%b d=%h want 2/0/%h", occ, up.ready, dn.data[31:0], a[31:0]);
      end
      step();
      total++;
      if (dn.data !== a[DW-1:0] || dn.valid !== 1'b1) begin
         bad++;
         $display("FAIL bp_hold: got v=%b d=%h want 1/%h", dn.valid, dn.data[31:0], a[31:0]);
      end
      dn.ready = 1'b1;
      step();
      total++;
      if (up.ready !== 1'b1 || occ !== 2'd1 || dn.data !== b[DW-1:0]) begin
         bad++;
         $display("FAIL bp_release: got rdy=%b occ=%0d d=%h want 1/1/%h", up.ready, occ, dn.data[31:0], b[31:0]);
      end
      step();
`else
      idle();
      #1;
      total++;
      if (up.ready !== 1'b0 || dn.data !== a[DW-1:0]) begin
         bad++;
         $display("FAIL bp_comb_low: got rdy=%b d=%h want 0/%h", up.ready, dn.data[31:0], a[31:0]);
      end
      dn.ready = 1'b1;
      #1;
      total++;
      if (up.ready !== 1'b1) begin
         bad++;
         $display("FAIL bp_comb_high: got rdy=%b want 1", up.ready);
      end
      step();
`endif
      total++;
      if (occ !== 2'd0 || dn.valid !== 1'b0) begin
         bad++;
         $display("FAIL bp_drain: got occ=%0d v=%b want 0/0", occ, dn.valid);
      end
   endtask

   task automatic test_flush();
      dn.ready = 1'b0;
      send('hA);
      step();
`ifdef PIPE_SKID_EN
      send('hB);
      step();
`endif
      send('hC);
      flush_i = 1'b1;
      step();
      flush_i = 1'b0;
      idle();
      total++;
      if (occ !== 2'd0 || dn.valid !== 1'b0 || dn.ctrl !== '0 || up.ready !== 1'b1) begin
         bad++;
         $display("FAIL flush_pulse: got occ=%0d v=%b c=%h rdy=%b want 0/0/0/1", occ, dn.valid, dn.ctrl, up.ready);
      end
      dn.ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         total++;
         if (dn.valid !== 1'b0) begin
            bad++;
            $display("FAIL flush_leak_%0d: got v=%b want 0", i, dn.valid);
         end
      end
      flush_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         send('hD0 + i);
         step();
         total++;
         if (occ !== 2'd0 || up.ready !== 1'b1) begin
            bad++;
            $display("FAIL flush_held_%0d: got occ=%0d rdy=%b want 0/1", i, occ, up.ready);
         end
      end
      flush_i = 1'b0;
      idle();
      step();
   endtask

   task automatic test_bubble();
      up.valid = 1'b0;
      up.ctrl  = '1;
      up.data  = '1;
      dn.ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         total++;
         if (dn.ctrl !== '0 || dn.valid !== 1'b0) begin
            bad++;
            $display("FAIL bubble_%0d: got c=%h v=%b want 0/0", i, dn.ctrl, dn.valid);
         end
      end
      idle();
   endtask

   task automatic test_reset_mid();
      dn.ready = 1'b0;
      send('h55);
      step();
`ifdef PIPE_SKID_EN
      send('h66);
      step();
`endif
      idle();
      #2 rst_n = 1'b0;
      #1;
      check_empty_outputs("reset_mid");
      @(negedge clk);
      #1 rst_n = 1'b1;
      dn.ready = 1'b1;
      step();
      step();
      total++;
      if (dn.valid !== 1'b0 || occ !== 2'd0) begin
         bad++;
         $display("FAIL reset_drop: got v=%b occ=%0d want 0/0", dn.valid, occ);
      end
   endtask

   initial begin
      idle();
      dn.ready = 1'b0;
      test_reset();
      test_stream();
      test_backpressure();
      test_flush();
      test_bubble();
      test_stream();
      test_reset_mid();
      step();
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL sb_leftover: got %0d want 0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
